// File: rtl/pulse_train_ch1.sv
// Pulse-train generator: on a rising PL_launch it emits num pulses of width
// cycles high, spaced period cycles apart, then holds PL_done until PL_launch drops.
module pulse_train_ch1 #(
    parameter int CNT_W = 36,
    parameter int NUM_W = 16
) (
    input  logic             clk_Pulse,
    input  logic             rst_n,
    input  logic             PL_launch,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] period,
    input  logic [NUM_W-1:0] num,
    output logic             PL_out,
    output logic             PL_busy,
    output logic             PL_done,
    output logic [NUM_W-1:0] pulse_cnt,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TIMER_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             launch_q;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [NUM_W-1:0] num_q, num_d;
    logic [NUM_W-1:0] cnt_q, cnt_d;
    logic             pl_out_q, pl_out_d;
    logic             pl_busy_q, pl_busy_d;
    logic             pl_done_q, pl_done_d;
    logic             cfg_err_q, cfg_err_d;
    logic             launch_rise_s;
    logic [CNT_W-1:0] low_len_s;

    assign launch_rise_s = PL_launch & ~launch_q;
    // Safe: a train is only accepted when period > width.
    assign low_len_s     = period_q - width_q;

    // State and output registers; launch_q resets high so a level held across reset never triggers.
    always_ff @(posedge clk_Pulse) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            launch_q  <= 1'b1;
            timer_q   <= '0;
            width_q   <= '0;
            period_q  <= '0;
            num_q     <= '0;
            cnt_q     <= '0;
            pl_out_q  <= 1'b0;
            pl_busy_q <= 1'b0;
            pl_done_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            launch_q  <= PL_launch;
            timer_q   <= timer_d;
            width_q   <= width_d;
            period_q  <= period_d;
            num_q     <= num_d;
            cnt_q     <= cnt_d;
            pl_out_q  <= pl_out_d;
            pl_busy_q <= pl_busy_d;
            pl_done_q <= pl_done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Next-state, timer and pulse-count logic.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        width_d   = width_q;
        period_d  = period_q;
        num_d     = num_q;
        cnt_d     = cnt_q;
        cfg_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (launch_rise_s) begin
                    if ((width == '0) || (num == '0) || (period <= width)) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        width_d  = width;
                        period_d = period;
                        num_d    = num;
                        cnt_d    = '0;
                        timer_d  = TIMER_ONE;
                        state_d  = S_HIGH;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HIGH: begin
                if (!PL_launch) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else if (timer_q == width_q) begin
                    state_d = S_LOW;
                    timer_d = TIMER_ONE;
                    cnt_d   = cnt_q + {{(NUM_W-1){1'b0}}, 1'b1};
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            S_LOW: begin
                if (!PL_launch) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else if (timer_q == low_len_s) begin
                    if (cnt_q == num_q) begin
                        state_d = S_DONE;
                        timer_d = '0;
                    end else begin
                        state_d = S_HIGH;
                        timer_d = TIMER_ONE;
                    end
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            S_DONE: begin
                if (!PL_launch) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, giving a clean 1-cycle latency.
    always_comb begin
        pl_out_d  = 1'b0;
        pl_busy_d = 1'b0;
        pl_done_d = 1'b0;
        case (state_d)
            S_HIGH: begin
                pl_out_d  = 1'b1;
                pl_busy_d = 1'b1;
            end
            S_LOW: begin
                pl_busy_d = 1'b1;
            end
            S_DONE: begin
                pl_done_d = 1'b1;
            end
            default: begin
                pl_out_d  = 1'b0;
            end
        endcase
    end

    assign PL_out    = pl_out_q;
    assign PL_busy   = pl_busy_q;
    assign PL_done   = pl_done_q;
    assign pulse_cnt = cnt_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: doc/pulse_train_ch1.md
PULSE_TRAIN_CH1 -- requirements
Module: pulse_train_ch1

Interface
REQ-001 SHALL provide parameter CNT_W, default 36, width of the width/period timing fields in clk_Pulse cycles.
REQ-002 SHALL provide parameter NUM_W, default 16, width of the pulse-count field.
REQ-003 SHALL provide port clk_Pulse, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL provide port rst_n, input, 1, reset: synchronous, active-low.
REQ-005 SHALL provide port PL_launch, input, 1, level trigger driven by the delay channel's launch_PL; rising edge starts a train, low aborts or re-arms.
REQ-006 SHALL provide port width, input, CNT_W, high time of each pulse in cycles.
REQ-007 SHALL provide port period, input, CNT_W, pulse repetition period in cycles.
REQ-008 SHALL provide port num, input, NUM_W, number of pulses per train.
REQ-009 SHALL provide port PL_out, output, 1, optical pulse drive.
REQ-010 SHALL provide port PL_busy, output, 1, high while a train is in progress.
REQ-011 SHALL provide port PL_done, output, 1, high after a complete train until PL_launch falls.
REQ-012 SHALL provide port pulse_cnt, output, NUM_W, number of pulses completed in the current or last train.
REQ-013 SHALL provide port cfg_err, output, 1, one-cycle strobe on a rejected launch.

Function
REQ-014 SHALL register PL_launch into launch_q; rising edge = PL_launch==1 and launch_q==0.
REQ-015 SHALL implement FSM states IDLE, HIGH, LOW, DONE.
REQ-016 On a rising edge in IDLE, SHALL latch width, period and num; later input changes SHALL NOT affect the running train.
REQ-017 SHALL reject the launch if width==0, num==0 or period<=width: pulse cfg_err for 1 cycle, stay in IDLE, leave pulse_cnt unchanged.
REQ-018 On an accepted launch, SHALL clear pulse_cnt, enter HIGH, and assert PL_out and PL_busy starting the cycle after the detecting edge (1-cycle latency).
REQ-019 In HIGH, SHALL hold PL_out=1 for exactly width cycles, then enter LOW.
REQ-020 In LOW, SHALL hold PL_out=0 for exactly period-width cycles, so each pulse starts exactly period cycles after the previous one.
REQ-021 SHALL increment pulse_cnt on each HIGH->LOW transition; pulse_cnt SHALL NOT wrap because it is bounded by num.
REQ-022 When LOW completes and pulse_cnt==num, SHALL enter DONE: PL_done=1, PL_busy=0, PL_out=0; otherwise it SHALL re-enter HIGH.
REQ-023 From DONE, SHALL return to IDLE the cycle after PL_launch is sampled low; PL_done SHALL clear on that transition.
REQ-024 PL_launch sampled low in HIGH or LOW SHALL abort: next cycle PL_out=0, PL_busy=0, state IDLE, PL_done stays 0, and pulse_cnt holds its partial value.
REQ-025 Rising edges outside IDLE SHALL be ignored; a new train requires PL_launch low and then high again.
REQ-026 Internal timers SHALL be CNT_W bits wide with no overflow for any legal width/period value.

Reset
REQ-027 With rst_n==0 at a clock edge: state=IDLE, PL_out=0, PL_busy=0, PL_done=0, cfg_err=0, pulse_cnt=0, timers=0.
REQ-028 SHALL reset launch_q to 1, so a PL_launch held high across reset release does not trigger; a low-then-high transition is required.
REQ-029 Reset asserted mid-train SHALL take priority over all other events and drop PL_out on that edge.

Verification
REQ-030 width=3, period=10, num=4, PL_launch rises at cycle 0 and stays high -> PL_out high cycles 1-3, 11-13, 21-23, 31-33; PL_done=1 from cycle 41; pulse_cnt=4.
REQ-031 width=0, or period=5 with width=5, or num=0 -> cfg_err=1 for one cycle, PL_out stays 0, PL_busy stays 0.
REQ-032 width=3, period=10, num=4, PL_launch dropped at cycle 15 -> PL_out=0 and PL_busy=0 from cycle 16, PL_done never set, pulse_cnt=2.
REQ-033 PL_launch high during reset and held high -> no pulse; low for 1 cycle then high -> train starts with 1-cycle latency.
REQ-034 width, period and num changed mid-train, plus extra PL_launch glitches while in DONE -> running train unaffected; no retrigger until PL_launch falls and rises again.
REQ-035 rst_n driven low during HIGH -> PL_out=0 at the next edge, all outputs at their reset values.
